aes_sbox_rand_gen: RTL
======================

AES_SBOX_RAND_GEN -- requirements
Module: aes_sbox_rand_gen

Interface
REQ-001 Parameter: SHARES, default 2, number of shares of the masked S-box being fed.
REQ-002 Parameter: BLIND_W, default 4, width of the blinding-randomness field (B) of the S-box.
REQ-003 Parameter: WARMUP, default 16, number of generator steps discarded after every seed load.
REQ-004 Derived: RND_W = 11*SHARES*(SHARES-1) + BLIND_W; NLANES = ceil(RND_W/32).
REQ-005 ClkxCI  in  1  clock; all state updates on the rising edge.
REQ-006 RstxBI  in  1  reset; synchronous, active-low.
REQ-007 SeedxDI  in  32  one seed word per transfer.
REQ-008 SeedValidxSI / SeedReadyxSO  in / out  1  seed handshake; a word transfers when both are high on an edge.
REQ-009 ReseedxSI  in  1  request a new seed load; sampled in RUN only.
REQ-010 EnxSI  in  1  consumer step enable; 0 holds all lane state and the output.
REQ-011 RndValidxSO  out  1  RndxDO holds fresh, usable randomness.
REQ-012 RndxDO  out  RND_W  fresh randomness, packed LSB-first: Zmul1 (4S(S-1)), Zmul2 (2S(S-1)), Zmul3 (2S(S-1)), Zinv1, Zinv2, Zinv3 (S(S-1) each), B (BLIND_W).
REQ-013 BusyxSO  out  1  high in LOAD or WARMUP.

Function
REQ-014 The generator SHALL consist of NLANES independent 32-bit Galois LFSRs, feedback mask 0x80200003 (x^32+x^22+x^2+x+1).
REQ-015 One generator step SHALL advance every lane by 32 single-bit Galois shifts, computed combinationally in one cycle.
REQ-016 RndxDO SHALL be the lower RND_W bits of {lane[NLANES-1], ..., lane[0]}, registered, so that output bits never repeat between consecutive valid cycles.
REQ-017 FSM states SHALL be IDLE, LOAD, WARMUP, and RUN.
REQ-018 IDLE: SeedReadyxSO=0; next state is LOAD.
REQ-019 LOAD: SeedReadyxSO=1; each transfer writes lane[k], with k counting 0..NLANES-1; after the transfer for k=NLANES-1, go to WARMUP.
REQ-020 A seed word of 0x00000000 SHALL be stored as 0x00000001 to avoid LFSR lock-up.
REQ-021 WARMUP: lanes step once per cycle regardless of EnxSI, for exactly WARMUP cycles, then go to RUN; if WARMUP=0, go to RUN directly.
REQ-022 RUN: RndValidxSO=1; when EnxSI=1, lanes step and RndxDO updates on the edge; when EnxSI=0, everything holds.
REQ-023 RUN with ReseedxSI=1 SHALL go to LOAD on the next edge, drop RndValidxSO, and clear the lane counter; ReseedxSI takes priority over EnxSI in that cycle.
REQ-024 RndValidxSO SHALL be 0 in every non-RUN state; RndxDO SHALL be held at all-zero outside RUN.
REQ-025 SeedValidxSI outside LOAD SHALL be ignored; ReseedxSI outside RUN SHALL be ignored.

Reset
REQ-026 On RstxBI=0 at an edge: state=IDLE, lanes=0, lane counter=0, warm-up counter=0, RndxDO=0, RndValidxSO=0, SeedReadyxSO=0, BusyxSO=0.
REQ-027 Reset asserted in any state, including mid-LOAD or mid-WARMUP, SHALL abort the operation; a full reseed is required afterwards.

Structure
REQ-028 The shared package aes_masking_pkg SHALL hold: the lane polynomial constant, the lane width (32), and functions rnd_width(SHARES, BLIND_W) and field offset functions, reused by the S-box.
REQ-029 One sub-module, lfsr32_step32, SHALL implement the combinational 32-shift lane update and be instantiated NLANES times.
REQ-030 Counters SHALL be sized $clog2(NLANES+1) and $clog2(WARMUP+1).

Verification
REQ-031 Reset, then feed seed 0x00000001 with SHARES=2, BLIND_W=4 (RND_W=26, NLANES=1) -> SeedReadyxSO is high for exactly 1 transfer; BusyxSO is high for 1+16 cycles; RndValidxSO rises on the 18th edge after reset release; RndxDO equals a golden-model Galois LFSR after 17 steps, low 26 bits.
REQ-032 Seed 0x00000000 -> same output as seed 0x00000001.
REQ-033 In RUN, hold EnxSI=0 for 5 cycles -> RndxDO constant; then set EnxSI=1 for 1000 cycles -> matches golden model every cycle with no two consecutive values equal.
REQ-034 Assert ReseedxSI and EnxSI together in RUN -> next cycle is LOAD, RndValidxSO=0, and the lanes do not step.
REQ-035 SHARES=3 (RND_W=70, NLANES=3); assert RstxBI after 2 of 3 seed words -> IDLE, all outputs 0, and a fresh 3-word load is required.
REQ-036 SeedValidxSI pulsed while in RUN -> no state change and output sequence unaffected.

Source files
------------

// File: rtl/aes_masking_pkg.sv
// Shared definitions for the masked AES S-box and its randomness source.
//
// Contents:
//   LANE_W / LANE_POLY   width and Galois feedback mask of one generator lane
//   rand_gen_state_e     control states of the randomness generator
//   rnd_field_e          names of the fields packed into the randomness word
//   rnd_width()          total randomness bits needed by an S-box instance
//   rnd_lanes()          number of 32-bit lanes needed to cover rnd_width()
//   field_offset()       LSB position of a field inside the randomness word
//   field_width()        width of a field inside the randomness word
package aes_masking_pkg;

  localparam int unsigned LANE_W = 32;
  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [LANE_W-1:0] LANE_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARMUP,
    ST_RUN
  } rand_gen_state_e;

  typedef enum logic [2:0] {
    FLD_ZMUL1,
    FLD_ZMUL2,
    FLD_ZMUL3,
    FLD_ZINV1,
    FLD_ZINV2,
    FLD_ZINV3,
    FLD_B
  } rnd_field_e;

  function automatic int unsigned rnd_width(input int unsigned shares,
                                            input int unsigned blind_w);
    return 11 * shares * (shares - 1) + blind_w;
  endfunction

  function automatic int unsigned rnd_lanes(input int unsigned shares,
                                            input int unsigned blind_w);
    return (rnd_width(shares, blind_w) + LANE_W - 1) / LANE_W;
  endfunction

  // Fields are packed LSB-first in the order of rnd_field_e.
  function automatic int unsigned field_offset(input int unsigned shares,
                                               input rnd_field_e fld);
    int unsigned p;
    int unsigned off;
    p = shares * (shares - 1);
    case (fld)
      FLD_ZMUL1: off = 0;
      FLD_ZMUL2: off = 4 * p;
      FLD_ZMUL3: off = 6 * p;
      FLD_ZINV1: off = 8 * p;
      FLD_ZINV2: off = 9 * p;
      FLD_ZINV3: off = 10 * p;
      default:   off = 11 * p;
    endcase
    return off;
  endfunction

  function automatic int unsigned field_width(input int unsigned shares,
                                              input int unsigned blind_w,
                                              input rnd_field_e fld);
    int unsigned p;
    int unsigned w;
    p = shares * (shares - 1);
    case (fld)
      FLD_ZMUL1: w = 4 * p;
      FLD_ZMUL2: w = 2 * p;
      FLD_ZMUL3: w = 2 * p;
      FLD_ZINV1: w = p;
      FLD_ZINV2: w = p;
      FLD_ZINV3: w = p;
      default:   w = blind_w;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lfsr32_step32.sv
// One generator step for a single 32-bit Galois lane: 32 consecutive
// single-bit right shifts with feedback mask LANE_POLY, fully combinational.
//
// Ports:
//   lane     current lane value
//   stepped  lane value after 32 shifts
module lfsr32_step32
  import aes_masking_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  output logic [LANE_W-1:0] stepped
);

  always_comb begin
    stepped = lane;
    for (int i = 0; i < 32; i++) begin
      stepped = (stepped >> 1) ^ (LANE_POLY & {LANE_W{stepped[0]}});
    end
  end

endmodule

// File: rtl/aes_sbox_rand_gen.sv
// Fresh-randomness generator for a masked AES S-box. NLANES independent
// 32-bit Galois LFSR lanes are seeded one word at a time, advanced through a
// discarded warm-up, and then stepped on demand; the low RND_W bits of the
// concatenated lanes form the registered randomness output.
//
// Ports:
//   ClkxCI        clock, rising edge
//   RstxBI        synchronous active-low reset
//   SeedxDI       seed word, lane 0 first
//   SeedValidxSI  seed word offered
//   SeedReadyxSO  seed word accepted (LOAD only)
//   ReseedxSI     request a new seed load (honoured in RUN only)
//   EnxSI         consumer step enable in RUN
//   RndValidxSO   RndxDO holds fresh randomness (RUN only)
//   RndxDO        randomness word, zero outside RUN
//   BusyxSO       seed load or warm-up in progress
module aes_sbox_rand_gen
  import aes_masking_pkg::*;
#(
  parameter  int unsigned SHARES  = 2,
  parameter  int unsigned BLIND_W = 4,
  parameter  int unsigned WARMUP  = 16,
  localparam int unsigned RND_W   = rnd_width(SHARES, BLIND_W)
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic [31:0]      SeedxDI,
  input  logic             SeedValidxSI,
  output logic             SeedReadyxSO,
  input  logic             ReseedxSI,
  input  logic             EnxSI,
  output logic             RndValidxSO,
  output logic [RND_W-1:0] RndxDO,
  output logic             BusyxSO
);

  localparam int unsigned NLANES = rnd_lanes(SHARES, BLIND_W);
  localparam int unsigned KCNT_W = $clog2(NLANES + 1);
  // A zero-length warm-up still needs a legal 1-bit counter.
  localparam int unsigned WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [KCNT_W-1:0] K_LAST = KCNT_W'(NLANES - 1);
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  rand_gen_state_e   state;
  rand_gen_state_e   state_next;
  logic [KCNT_W-1:0] lane_cnt;
  logic [KCNT_W-1:0] lane_cnt_next;
  logic [WCNT_W-1:0] warm_cnt;
  logic [WCNT_W-1:0] warm_cnt_next;

  logic [LANE_W-1:0] lane      [NLANES];
  logic [LANE_W-1:0] lane_next [NLANES];
  logic [LANE_W-1:0] step_in   [NLANES];
  logic [LANE_W-1:0] step_out  [NLANES];

  logic [LANE_W-1:0] seed_word;
  logic              seed_xfer;
  logic              run_step;
  logic [RND_W-1:0]  rnd_next;

  // An all-zero lane would lock the LFSR, so zero seeds become one.
  assign seed_word = (SeedxDI == '0) ? LANE_W'(1) : SeedxDI;
  assign seed_xfer = (state == ST_LOAD) && SeedValidxSI;
  // Reseed wins over enable: the lanes stay put on the cycle that leaves RUN.
  assign run_step  = (state == ST_RUN) && EnxSI && !ReseedxSI;

  // During LOAD the stepper sees the incoming seed, so a lane is written with
  // the seed already advanced once; together with WARMUP steps the first RUN
  // output is WARMUP+1 steps past the seed.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      step_in[i] = (state == ST_LOAD) ? seed_word : lane[i];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    lfsr32_step32 u_step (
      .lane    (step_in[g]),
      .stepped (step_out[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      lane_next[i] = lane[i];
      if ((seed_xfer && (lane_cnt == KCNT_W'(i))) || (state == ST_WARMUP) || run_step) begin
        lane_next[i] = step_out[i];
      end
    end
  end

  // Output word is taken from the lane values being written, so it is already
  // current on the edge that enters RUN and tracks every RUN step.
  always_comb begin
    rnd_next = '0;
    if (state_next == ST_RUN) begin
      for (int b = 0; b < RND_W; b++) begin
        rnd_next[b] = lane_next[b / LANE_W][b % LANE_W];
      end
    end
  end

  always_comb begin
    state_next    = state;
    lane_cnt_next = lane_cnt;
    warm_cnt_next = warm_cnt;
    SeedReadyxSO  = 1'b0;
    BusyxSO       = 1'b0;
    RndValidxSO   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next    = ST_LOAD;
        lane_cnt_next = '0;
      end
      ST_LOAD: begin
        SeedReadyxSO = 1'b1;
        BusyxSO      = 1'b1;
        if (SeedValidxSI) begin
          if (lane_cnt == K_LAST) begin
            lane_cnt_next = '0;
            warm_cnt_next = '0;
            state_next    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end else begin
            lane_cnt_next = lane_cnt + 1'b1;
          end
        end
      end
      ST_WARMUP: begin
        BusyxSO = 1'b1;
        if (warm_cnt == W_LAST) begin
          warm_cnt_next = '0;
          state_next    = ST_RUN;
        end else begin
          warm_cnt_next = warm_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        RndValidxSO = 1'b1;
        if (ReseedxSI) begin
          state_next    = ST_LOAD;
          lane_cnt_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      state    <= ST_IDLE;
      lane_cnt <= '0;
      warm_cnt <= '0;
      RndxDO   <= '0;
      for (int i = 0; i < NLANES; i++) begin
        lane[i] <= '0;
      end
    end else begin
      state    <= state_next;
      lane_cnt <= lane_cnt_next;
      warm_cnt <= warm_cnt_next;
      RndxDO   <= rnd_next;
      for (int i = 0; i < NLANES; i++) begin
        lane[i] <= lane_next[i];
      end
    end
  end

endmodule
